// File: rtl/axi_defs.sv
// Shared AXI constants, the chunker state encoding and a response-merge helper
// used across the SDRAM write path.
package axi_defs;
    localparam logic [1:0] BURST_INCR      = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam int         CHUNK_BEATS     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP,
        ST_DONE
    } chunk_state_e;

    // AXI response codes are ordered by severity, so worst-wins merging is a plain max.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/axi_wr_chunker.sv
// Splits AXI4 INCR write bursts into aligned 4-beat sub-bursts for the SDRAM
// write datapath and folds the per-chunk responses into one response per burst.
module axi_wr_chunker
    import axi_defs::*;
#(
    parameter int ADDRS        = 32,
    parameter int WIDTH        = 32,
    parameter int MASKS        = WIDTH / 8,
    parameter int AXI_ID_WIDTH = 4,
    parameter int CBITS        = 7
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    s_awvalid_i,
    output logic                    s_awready_o,
    input  logic [ADDRS-1:0]        s_awaddr_i,
    input  logic [AXI_ID_WIDTH-1:0] s_awid_i,
    input  logic [7:0]              s_awlen_i,
    input  logic [1:0]              s_awburst_i,

    input  logic                    s_wvalid_i,
    output logic                    s_wready_o,
    input  logic                    s_wlast_i,
    input  logic [MASKS-1:0]        s_wstrb_i,
    input  logic [WIDTH-1:0]        s_wdata_i,

    output logic                    s_bvalid_o,
    input  logic                    s_bready_i,
    output logic [1:0]              s_bresp_o,
    output logic [AXI_ID_WIDTH-1:0] s_bid_o,

    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [ADDRS-1:0]        m_awaddr_o,
    output logic [AXI_ID_WIDTH-1:0] m_awid_o,
    output logic [7:0]              m_awlen_o,
    output logic [1:0]              m_awburst_o,

    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    output logic                    m_wlast_o,
    output logic [MASKS-1:0]        m_wstrb_o,
    output logic [WIDTH-1:0]        m_wdata_o,

    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    input  logic [1:0]              m_bresp_i,
    input  logic [AXI_ID_WIDTH-1:0] m_bid_i
);
    localparam logic [ADDRS-1:0] CHUNK_BYTES = ADDRS'(CHUNK_BEATS * MASKS);
    localparam logic [CBITS-1:0] OUT_MAX     = '1;

    chunk_state_e     state_q;
    logic [7:0]       len_q;
    logic [6:0]       chunks_left_q;
    logic [8:0]       src_cnt_q;
    logic [1:0]       beat_q;
    logic [1:0]       merged_q, merged_d;
    logic [CBITS-1:0] outstanding_q, outstanding_d;

    logic src_phase;
    logic aw_in_fire, aw_out_fire, w_in_fire, w_out_fire, b_in_fire, b_out_fire;

    assign m_awlen_o   = 8'd3;
    assign m_awburst_o = BURST_INCR;

    // Source beats still owed by the master; beyond that the chunk is padded.
    assign src_phase = (src_cnt_q <= {1'b0, len_q});

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        m_wvalid_o = 1'b0;
        m_wlast_o  = 1'b0;
        m_wdata_o  = '0;
        m_wstrb_o  = '0;
        s_wready_o = 1'b0;
        if (state_q == ST_DATA) begin
            m_wlast_o = (beat_q == 2'd3);
            if (src_phase) begin
                m_wvalid_o = s_wvalid_i;
                s_wready_o = m_wready_i;
                m_wdata_o  = s_wdata_i;
                m_wstrb_o  = s_wstrb_i;
            end else begin
                m_wvalid_o = 1'b1;
            end
        end
    end

    assign aw_in_fire  = s_awvalid_i & s_awready_o;
    assign aw_out_fire = m_awvalid_o & m_awready_i;
    assign w_in_fire   = s_wvalid_i  & s_wready_o;
    assign w_out_fire  = m_wvalid_o  & m_wready_i;
    assign b_in_fire   = m_bvalid_i  & m_bready_o;
    assign b_out_fire  = s_bvalid_o  & s_bready_i;

    always_comb begin
        merged_d = merged_q;
        if (b_in_fire) begin
            merged_d = resp_max(merged_d, m_bresp_i);
            if (m_bid_i != m_awid_o)
                merged_d = AXI_RESP_SLVERR;
        end
        if (w_in_fire && (s_wlast_i != (src_cnt_q == {1'b0, len_q})))
            merged_d = AXI_RESP_SLVERR;
    end

    always_comb begin
        case ({aw_out_fire, b_in_fire})
            2'b10:   outstanding_d = outstanding_q + CBITS'(1);
            2'b01:   outstanding_d = outstanding_q - CBITS'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            chunks_left_q <= '0;
            src_cnt_q     <= '0;
            beat_q        <= '0;
            merged_q      <= AXI_RESP_OKAY;
            outstanding_q <= '0;
            s_awready_o   <= 1'b0;
            s_bvalid_o    <= 1'b0;
            s_bresp_o     <= '0;
            s_bid_o       <= '0;
            m_awvalid_o   <= 1'b0;
            m_awaddr_o    <= '0;
            m_awid_o      <= '0;
            m_bready_o    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values,
            // letting a later branch cleanly override the default merge update.
            outstanding_q <= outstanding_d;
            merged_q      <= merged_d;
            case (state_q)
                ST_IDLE: begin
                    if (aw_in_fire) begin
                        s_awready_o   <= 1'b0;
                        m_awvalid_o   <= 1'b1;
                        m_awaddr_o    <= s_awaddr_i;
                        m_awid_o      <= s_awid_i;
                        len_q         <= s_awlen_i;
                        chunks_left_q <= 7'(s_awlen_i >> 2) + 7'd1;
                        src_cnt_q     <= '0;
                        beat_q        <= '0;
                        merged_q      <= (s_awburst_i == BURST_INCR) ? AXI_RESP_OKAY
                                                                     : AXI_RESP_SLVERR;
                        m_bready_o    <= 1'b1;
                        state_q       <= ST_ADDR;
                    end else begin
                        s_awready_o <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (aw_out_fire) begin
                        m_awvalid_o <= 1'b0;
                        state_q     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_in_fire)
                        src_cnt_q <= src_cnt_q + 9'd1;
                    if (w_out_fire) begin
                        beat_q <= beat_q + 2'd1;
                        if (beat_q == 2'd3) begin
                            if (chunks_left_q == 7'd1) begin
                                state_q <= ST_RESP;
                            end else begin
                                chunks_left_q <= chunks_left_q - 7'd1;
                                m_awaddr_o    <= m_awaddr_o + CHUNK_BYTES;
                                m_awvalid_o   <= 1'b1;
                                state_q       <= ST_ADDR;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (outstanding_q == '0) begin
                        s_bvalid_o <= 1'b1;
                        s_bresp_o  <= merged_d;
                        s_bid_o    <= m_awid_o;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (b_out_fire) begin
                        s_bvalid_o  <= 1'b0;
                        m_bready_o  <= 1'b0;
                        s_awready_o <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The datapath never holds more than 64 chunks; saturating the counter means it lost track.
    assert property (@(posedge clock) disable iff (reset) outstanding_q != OUT_MAX)
        else $fatal(1, "axi_wr_chunker: outstanding chunk counter saturated");

endmodule

// File: tb/tb_axi_wr_chunker.sv
// Scoreboard bench for axi_wr_chunker: expected chunk AW, W beats and merged B
// are queued as each burst is set up and popped as the DUT produces them.
module tb_axi_wr_chunker;
    import axi_defs::*;

    logic        clock, reset;
    logic        s_awvalid_i, s_awready_o;
    logic [31:0] s_awaddr_i;
    logic [3:0]  s_awid_i;
    logic [7:0]  s_awlen_i;
    logic [1:0]  s_awburst_i;
    logic        s_wvalid_i, s_wready_o, s_wlast_i;
    logic [3:0]  s_wstrb_i;
    logic [31:0] s_wdata_i;
    logic        s_bvalid_o, s_bready_i;
    logic [1:0]  s_bresp_o;
    logic [3:0]  s_bid_o;
    logic        m_awvalid_o, m_awready_i;
    logic [31:0] m_awaddr_o;
    logic [3:0]  m_awid_o;
    logic [7:0]  m_awlen_o;
    logic [1:0]  m_awburst_o;
    logic        m_wvalid_o, m_wready_i, m_wlast_o;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_wdata_o;
    logic        m_bvalid_i, m_bready_o;
    logic [1:0]  m_bresp_i;
    logic [3:0]  m_bid_i;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        pad;
    } w_exp_t;

    logic [31:0] exp_aw_q[$];
    w_exp_t      exp_w_q[$];
    logic [5:0]  exp_b_q[$];
    logic [1:0]  pend_resp_q[$];
    logic [3:0]  pend_id_q[$];

    int n_cmp = 0;
    int n_err = 0;

    axi_wr_chunker dut (
        .clock(clock), .reset(reset),
        .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awaddr_i(s_awaddr_i),
        .s_awid_i(s_awid_i), .s_awlen_i(s_awlen_i), .s_awburst_i(s_awburst_i),
        .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .s_wlast_i(s_wlast_i),
        .s_wstrb_i(s_wstrb_i), .s_wdata_i(s_wdata_i),
        .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bresp_o(s_bresp_o), .s_bid_o(s_bid_o),
        .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
        .m_awid_o(m_awid_o), .m_awlen_o(m_awlen_o), .m_awburst_o(m_awburst_o),
        .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wlast_o(m_wlast_o),
        .m_wstrb_o(m_wstrb_o), .m_wdata_o(m_wdata_o),
        .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i), .m_bid_i(m_bid_i)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [48:0] reset_view();
        return {s_awready_o, s_wready_o, s_bvalid_o, m_awvalid_o, m_wvalid_o, m_wlast_o,
                m_bready_o, s_bresp_o, s_bid_o, m_awaddr_o, m_awid_o};
    endfunction

    task automatic drive_idle();
        s_awvalid_i = 1'b0; s_awaddr_i = '0; s_awid_i = '0; s_awlen_i = '0; s_awburst_i = '0;
        s_wvalid_i = 1'b0; s_wlast_i = 1'b0; s_wstrb_i = '0; s_wdata_i = '0;
        s_bready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        m_bvalid_i = 1'b0; m_bresp_i = '0; m_bid_i = '0;
    endtask

    // Runs one upstream burst against a model of the downstream datapath.
    // Called and returning at posedge+1; abort_at >= 0 stops after that many source beats.
    task automatic run_burst(input string name, input logic [31:0] addr, input logic [3:0] id,
                             input logic [7:0] len, input logic [1:0] burst, input int err_chunk,
                             input int bid_chunk, input bit stall, input bit bad_wlast,
                             input int abort_at, input logic [31:0] dbase);
        logic [31:0] src_data [256];
        logic [3:0]  src_strb [256];
        logic [1:0]  exp_resp;
        logic [31:0] ea;
        logic [5:0]  eb;
        w_exp_t      we;
        int nch, src_idx, beats_out, aw_cyc, maw_cyc, sidx;
        bit aw_sent, done;

        nch = (int'(len) >> 2) + 1;
        exp_aw_q.delete(); exp_w_q.delete(); exp_b_q.delete();
        pend_resp_q.delete(); pend_id_q.delete();
        exp_resp = (burst == BURST_INCR) ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        if (err_chunk >= 0 || bid_chunk >= 0 || bad_wlast) exp_resp = AXI_RESP_SLVERR;
        for (int i = 0; i <= int'(len); i++) begin
            src_data[i] = dbase + 32'(i);
            src_strb[i] = stall ? 4'($urandom) : 4'hF;
        end
        for (int c = 0; c < nch; c++) exp_aw_q.push_back(addr + 32'(16 * c));
        for (int i = 0; i < nch * 4; i++) begin
            we.pad  = (i > int'(len));
            we.last = ((i % 4) == 3);
            we.data = we.pad ? 32'h0 : src_data[i];
            we.strb = we.pad ? 4'h0 : src_strb[i];
            exp_w_q.push_back(we);
        end
        exp_b_q.push_back({id, exp_resp});

        aw_sent = 0; done = 0; src_idx = 0; beats_out = 0; aw_cyc = -1; maw_cyc = -1;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            sidx = (src_idx <= int'(len)) ? src_idx : 0;
            s_awvalid_i = !aw_sent; s_awaddr_i = addr; s_awid_i = id;
            s_awlen_i = len; s_awburst_i = burst;
            s_wvalid_i = (src_idx <= int'(len)) && (!stall || $urandom_range(1) == 1);
            s_wdata_i = src_data[sidx]; s_wstrb_i = src_strb[sidx];
            s_wlast_i = (src_idx == int'(len)) ^ (bad_wlast && src_idx == 0);
            m_awready_i = !stall || $urandom_range(1) == 1;
            m_wready_i  = !stall || $urandom_range(1) == 1;
            m_bvalid_i  = (pend_resp_q.size() > 0) && (!stall || $urandom_range(1) == 1);
            m_bresp_i   = (pend_resp_q.size() > 0) ? pend_resp_q[0] : 2'b00;
            m_bid_i     = (pend_id_q.size() > 0) ? pend_id_q[0] : 4'h0;
            s_bready_i  = !stall || $urandom_range(1) == 1;

            @(negedge clock);
            if (s_awvalid_i && s_awready_o) begin aw_sent = 1; aw_cyc = cyc; end
            if (m_awvalid_o && maw_cyc < 0) maw_cyc = cyc;
            if (m_awvalid_o && m_awready_i) begin
                n_cmp++;
                if (exp_aw_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s chunk_aw: unexpected chunk at %h", name, m_awaddr_o);
                end else begin
                    ea = exp_aw_q.pop_front();
                    if ({m_awaddr_o, m_awid_o, m_awlen_o, m_awburst_o} !== {ea, id, 8'd3, BURST_INCR}) begin
                        n_err++;
                        $display("FAIL %s chunk_aw: got addr=%h id=%h len=%h burst=%b, want addr=%h id=%h len=03 burst=01",
                                 name, m_awaddr_o, m_awid_o, m_awlen_o, m_awburst_o, ea, id);
                    end
                end
            end
            if (m_wvalid_o && m_wready_i) begin
                n_cmp++;
                if (exp_w_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s w_beat: unexpected beat data=%h", name, m_wdata_o);
                end else begin
                    we = exp_w_q.pop_front();
                    if ({m_wdata_o, m_wstrb_o, m_wlast_o} !== {we.data, we.strb, we.last}) begin
                        n_err++;
                        $display("FAIL %s w_beat %0d: got data=%h strb=%h last=%b, want data=%h strb=%h last=%b",
                                 name, beats_out, m_wdata_o, m_wstrb_o, m_wlast_o, we.data, we.strb, we.last);
                    end
                    if (we.pad) begin
                        n_cmp++;
                        if (s_wready_o !== 1'b0) begin
                            n_err++;
                            $display("FAIL %s pad_wready: got s_wready=%b, want 0", name, s_wready_o);
                        end
                    end
                    if (we.last) begin
                        pend_resp_q.push_back((beats_out / 4 == err_chunk) ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
                        pend_id_q.push_back((beats_out / 4 == bid_chunk) ? (id ^ 4'h1) : id);
                    end
                end
                beats_out++;
            end
            if (s_wvalid_i && s_wready_o) src_idx++;
            if (m_bvalid_i && m_bready_o) begin
                void'(pend_resp_q.pop_front());
                void'(pend_id_q.pop_front());
            end
            if (s_bvalid_o && s_bready_i) begin
                n_cmp++;
                if (exp_b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s s_b: unexpected response resp=%b", name, s_bresp_o);
                end else begin
                    eb = exp_b_q.pop_front();
                    if ({s_bid_o, s_bresp_o} !== eb) begin
                        n_err++;
                        $display("FAIL %s s_b: got id=%h resp=%b, want id=%h resp=%b",
                                 name, s_bid_o, s_bresp_o, eb[5:2], eb[1:0]);
                    end
                end
                done = 1;
            end
            @(posedge clock); #1;
            if (abort_at >= 0 && src_idx >= abort_at) return;
        end
        drive_idle();

        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s timeout: got no merged response within 3000 cycles, want one", name);
        end
        n_cmp++;
        if (exp_aw_q.size() + exp_w_q.size() + exp_b_q.size() != 0) begin
            n_err++;
            $display("FAIL %s leftover: got %0d aw / %0d w / %0d b unconsumed, want 0",
                     name, exp_aw_q.size(), exp_w_q.size(), exp_b_q.size());
        end
        n_cmp++;
        if (dut.outstanding_q !== '0) begin
            n_err++;
            $display("FAIL %s outstanding: got %0d, want 0", name, dut.outstanding_q);
        end
        n_cmp++;
        if (maw_cyc - aw_cyc != 1) begin
            n_err++;
            $display("FAIL %s aw_latency: got %0d cycles, want 1", name, maw_cyc - aw_cyc);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_cmp++;
        if (reset_view() !== '0 || dut.outstanding_q !== '0 || dut.state_q !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_values: got outputs=%h outstanding=%0d state=%0d, want all 0",
                     reset_view(), dut.outstanding_q, dut.state_q);
        end
        reset = 1'b0;
        n_cmp++;
        if (s_awready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_awready_early: got %b, want 0", s_awready_o);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (s_awready_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_awready_rise: got %b, want 1", s_awready_o);
        end
    endtask

    task automatic test_single();
        run_burst("single", 32'h100, 4'h5, 8'd3, BURST_INCR, -1, -1, 0, 0, -1, 32'hA0);
    endtask

    task automatic test_multi_chunk();
        run_burst("multi", 32'h200, 4'h3, 8'd15, BURST_INCR, -1, -1, 0, 0, -1, 32'h1000);
    endtask

    task automatic test_padding();
        run_burst("padding", 32'h300, 4'h7, 8'd5, BURST_INCR, -1, -1, 0, 0, -1, 32'h2000);
    endtask

    task automatic test_stall();
        run_burst("stall", 32'h400, 4'h9, 8'd15, BURST_INCR, -1, -1, 1, 0, -1, 32'h3000);
        run_burst("stall_pad", 32'h440, 4'h2, 8'd9, BURST_INCR, -1, -1, 1, 0, -1, 32'h3100);
    endtask

    task automatic test_errors();
        run_burst("chunk_err", 32'h500, 4'h4, 8'd15, BURST_INCR, 1, -1, 0, 0, -1, 32'h4000);
        run_burst("bid_err", 32'h600, 4'h6, 8'd7, BURST_INCR, -1, 0, 0, 0, -1, 32'h5000);
        run_burst("wlast_err", 32'h700, 4'h8, 8'd7, BURST_INCR, -1, -1, 0, 1, -1, 32'h6000);
        run_burst("non_incr", 32'h800, 4'hA, 8'd3, 2'b10, -1, -1, 0, 0, -1, 32'h7000);
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_len0", 32'h900, 4'hB, 8'd0, BURST_INCR, -1, -1, 0, 0, -1, 32'h8000);
        run_burst("b2b_len255", 32'h1000, 4'hC, 8'd255, BURST_INCR, -1, -1, 0, 0, -1, 32'h9000);
    endtask

    task automatic test_reset_mid();
        run_burst("mid_abort", 32'h2000, 4'hD, 8'd15, BURST_INCR, -1, -1, 0, 0, 5, 32'hA000);
        drive_idle();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_cmp++;
        if (reset_view() !== '0 || dut.outstanding_q !== '0 || dut.state_q !== ST_IDLE) begin
            n_err++;
            $display("FAIL mid_reset_values: got outputs=%h outstanding=%0d state=%0d, want all 0",
                     reset_view(), dut.outstanding_q, dut.state_q);
        end
        @(posedge clock); #1;
        n_cmp++;
        if (s_awready_o !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_awready: got %b, want 1", s_awready_o);
        end
        run_burst("after_reset", 32'h3000, 4'hE, 8'd3, BURST_INCR, -1, -1, 0, 0, -1, 32'hB000);
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_chunk();
        test_padding();
        test_stall();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_wr_chunker.md
# axi_wr_chunker

Splits arbitrary-length AXI4 INCR write bursts from an upstream master into fixed 4-beat, chunk-aligned sub-bursts (awlen = 3). It sits directly upstream of the AXI-to-SDRAM write datapath, which accepts only 4-beat INCR bursts. Each chunk's write-response from the datapath is collected. Exactly one merged write-response is returned to the master per original burst.

## Interface
- ADDRS, 32, address width
- WIDTH, 32, data width
- MASKS, WIDTH/8, byte-strobe width
- AXI_ID_WIDTH, 4, AXI ID width
- CBITS, 7, width of the outstanding-chunk counter (≥ 7 bits for 64 chunks)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_awvalid_i/s_awready_o  in/out  1  upstream AW handshake
- s_awaddr_i  in  ADDRS  burst base; low log2(4·MASKS) bits must be zero
- s_awid_i  in  AXI_ID_WIDTH  burst ID
- s_awlen_i  in  8  beats−1
- s_awburst_i  in  2  must be INCR (2'b01)
- s_wvalid_i/s_wready_o  in/out  1  upstream W handshake
- s_wlast_i  in  1  upstream last beat
- s_wstrb_i  in  MASKS  byte strobes
- s_wdata_i  in  WIDTH  write data
- s_bvalid_o/s_bready_i  out/in  1  merged response handshake
- s_bresp_o  out  2  merged response
- s_bid_o  out  AXI_ID_WIDTH  ID of the burst being answered
- m_awvalid_o/m_awready_i  out/in  1  chunk AW handshake to the write datapath
- m_awaddr_o  out  ADDRS  chunk address
- m_awid_o  out  AXI_ID_WIDTH  copy of s_awid
- m_awlen_o  out  8  constant 8'd3
- m_awburst_o  out  2  constant 2'b01
- m_wvalid_o/m_wready_i  out/in  1  chunk W handshake
- m_wlast_o  out  1  asserted on beat 3 of each chunk
- m_wstrb_o  out  MASKS  chunk strobes
- m_wdata_o  out  WIDTH  chunk data
- m_bvalid_i/m_bready_o  in/out  1  chunk response handshake
- m_bresp_i  in  2  chunk response
- m_bid_i  in  AXI_ID_WIDTH  chunk response ID

## Operation
- FSM states:
  - ST_IDLE: s_awready=1. On s_awvalid&s_awready, latch addr, id and len, set chunks = (len>>2)+1, clear merged resp → ST_ADDR.
  - ST_ADDR: m_awvalid=1. On m_awready, outstanding += 1 → ST_DATA.
  - ST_DATA: forward 4 beats, beat index b = 0..3.
    - While the source beat count ≤ len: s_wready = m_wready, and the source beat passes through unchanged.
    - After source beat len has been taken: padding beats are issued with m_wvalid=1, wdata=0, wstrb=0 and s_wready=0.
    - On beat 3 accepted: if the last chunk → ST_RESP; else address += 4·MASKS → ST_ADDR.
  - ST_RESP: wait for outstanding == 0 → ST_DONE.
  - ST_DONE: s_bvalid=1 with merged resp and latched ID. On s_bready → ST_IDLE.
- m_bready=1 in every state except IDLE.
- Each accepted chunk response decrements outstanding.
- Merge rule: merged = max(merged, m_bresp).
- Errors:
  - A chunk response with m_bid ≠ latched ID forces merged = SLVERR (2'b10).
  - If s_wlast_i on an accepted source beat disagrees with (source count == len), merged = SLVERR.
  - Source beats are counted by len only; s_wlast is never used to end the burst.
- Non-INCR bursts are accepted and treated as INCR with merged = SLVERR.

## Timing
- Reset values:
  - s_awready, s_wready, s_bvalid, m_awvalid, m_wvalid, m_wlast, m_bready = 0.
  - s_bresp = 0, s_bid = 0, m_awaddr = 0, m_awid = 0.
  - State = ST_IDLE, outstanding = 0.
- s_awready rises 1 cycle after reset deasserts.
- Datapath latency:
  - W path is combinational pass-through (m_wvalid = s_wvalid during source beats); zero added latency.
  - AW: first chunk m_awvalid asserts the cycle after s_aw acceptance.
  - Later chunks assert m_awvalid the cycle after the previous chunk's beat 3.
- All outputs in the AW/B paths are registered.
- Simultaneous chunk AW acceptance and chunk B acceptance in the same cycle: outstanding unchanged.
- Outstanding never exceeds 64. Reaching 2^CBITS−1 is a simulation $fatal.
- s_bvalid holds until s_bready. No new AW is accepted until the response handshake completes.
- Reset mid-burst:
  - All state is cleared the next cycle.
  - Partially forwarded chunks are abandoned.
  - The downstream is reset by the same signal.

## Structure
- Shared package `axi_defs`: BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10, CHUNK_BEATS = 4.
- Single flat module, no sub-modules. The outstanding counter and the beat counters are inline.

## Test plan
- awaddr=0x100, awlen=3, data 0xA0..0xA3:
  - One chunk at 0x100, m_wlast on beat 3.
  - One s_b with OKAY and the original ID.
- awaddr=0x200, awlen=15:
  - Four chunks at 0x200, 0x210, 0x220, 0x230, each with awlen=3.
  - 16 data beats in order, then a single s_bresp=OKAY.
- awlen=5:
  - Two chunks. Beats 6 and 7 have wstrb=0 and wdata=0.
  - s_wready is low during padding. One response.
- awlen=15 with random m_wready, m_awready and s_wvalid stalls (≈50%):
  - Data order preserved, no beat lost or duplicated.
  - Outstanding returns to 0.
- Second chunk's m_bresp=SLVERR, others OKAY: s_bresp=2'b10.
- Mismatched m_bid: s_bresp=2'b10.
- Reset asserted after beat 5 of a 16-beat burst:
  - Next cycle all outputs are at reset values; then s_awready=1.
  - A fresh awlen=3 burst then completes normally.
